// File: rtl/hamming_secded_dec_pipe_pkg.sv
// ---------------------------------------------------------------------------
// hamming_secded_pkg
// Shared definitions for the extended-Hamming (SECDED) decoder family.
//   calc_checkb(width) : number of Hamming check bits for a payload width
//   is_pow2(pos)       : true when a codeword position holds a check bit
//   data_pos(idx)      : codeword position of payload bit idx
//   err_class_e        : per-beat classification {CLEAN, SEC, DED}
// No ports; imported by the interface, the core and the pipeline top.
// ---------------------------------------------------------------------------
package hamming_secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } err_class_e;

    // Smallest r with 2^r >= width + r + 1.
    function automatic int calc_checkb(input int width);
        int res;
        res = 0;
        for (int k = 1; k < 16; k++) begin
            if (res == 0 && (1 << k) >= width + k + 1) begin
                res = k;
            end
        end
        return res;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Payload bits fill the non-power-of-two positions from 3 upwards;
    // position 0 is the overall parity bit.
    function automatic int data_pos(input int idx);
        int res;
        int cnt;
        res = 0;
        cnt = 0;
        for (int p = 3; p < 256; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx && res == 0) begin
                    res = p;
                end
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_pipe_if.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec_pipe_if
// Streaming bus of the pipelined SECDED decoder. Signal names are written
// from the decoder's point of view.
//   valid_i / ready_o / hv_i          : codeword input handshake
//   valid_o / ready_i / data_o        : result output handshake
//   sec_o / ded_o                     : per-beat error flags
// Modports: slave = decoder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface hamming_secded_dec_pipe_if #(
    parameter int DATA_WIDTH = 26
);
    import hamming_secded_pkg::*;

    localparam int CW_WIDTH = DATA_WIDTH + calc_checkb(DATA_WIDTH) + 1;

    logic                  valid_i;
    logic                  ready_o;
    logic [CW_WIDTH-1:0]   hv_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  sec_o;
    logic                  ded_o;

    modport slave (
        input  valid_i, hv_i, ready_i,
        output ready_o, valid_o, data_o, sec_o, ded_o
    );

    modport master (
        output valid_i, hv_i, ready_i,
        input  ready_o, valid_o, data_o, sec_o, ded_o
    );

endinterface

// File: rtl/hamming_secded_dec_pipe_core.sv
// ---------------------------------------------------------------------------
// hamming_secded_core
// Purely combinational SECDED check: syndrome, classification, correction.
//   i_cw    : codeword (bit 0 overall parity, power-of-two positions check
//             bits, other positions payload LSB-first)
//   o_data  : corrected payload (raw payload when uncorrectable)
//   o_class : CLEAN / SEC / DED
//   o_syn   : {overall parity, syndrome}
// ---------------------------------------------------------------------------
module hamming_secded_core
    import hamming_secded_pkg::*;
#(
    parameter  int DATA_WIDTH = 26,
    localparam int N_CHECKB   = calc_checkb(DATA_WIDTH),
    localparam int CW_WIDTH   = DATA_WIDTH + N_CHECKB + 1
) (
    input  logic [CW_WIDTH-1:0]   i_cw,
    output logic [DATA_WIDTH-1:0] o_data,
    output err_class_e            o_class,
    output logic [N_CHECKB:0]     o_syn
);

    logic [N_CHECKB-1:0] w_syn;
    logic                w_par;
    logic                w_doFlip;
    logic [CW_WIDTH-1:0] w_corr;

    // Positions 1..CW_WIDTH-1 whose index has bit k set.
    function automatic logic [CW_WIDTH-1:0] synMask(input int k);
        logic [CW_WIDTH-1:0] m;
        m = '0;
        for (int p = 1; p < CW_WIDTH; p++) begin
            if (((p >> k) & 1) == 1) begin
                m[p] = 1'b1;
            end
        end
        return m;
    endfunction

    for (genvar gk = 0; gk < N_CHECKB; gk++) begin : g_syn
        localparam logic [CW_WIDTH-1:0] MASK = synMask(gk);
        assign w_syn[gk] = ^(i_cw & MASK);
    end

    assign w_par = ^i_cw;
    assign o_syn = {w_par, w_syn};

    // Odd overall parity means one flip: syndrome 0 points at the parity
    // bit itself, otherwise at the flipped position unless that position
    // lies beyond the codeword. Even parity with a syndrome is a double.
    always_comb begin
        o_class  = CLEAN;
        w_doFlip = 1'b0;
        if (w_par) begin
            if (w_syn == '0) begin
                o_class = SEC;
            end else if (int'(w_syn) < CW_WIDTH) begin
                o_class  = SEC;
                w_doFlip = 1'b1;
            end else begin
                o_class = DED;
            end
        end else if (w_syn != '0) begin
            o_class = DED;
        end
    end

    assign w_corr = w_doFlip ? (i_cw ^ ({{(CW_WIDTH-1){1'b0}}, 1'b1} << w_syn))
                             : i_cw;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
        localparam int POS = data_pos(gi);
        assign o_data[gi] = w_corr[POS];
    end

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec_pipe
// One-stage pipelined SECDED decoder with valid/ready flow control and
// saturating error bookkeeping.
//   clk_i, rstn_i      : clock, synchronous active-low reset
//   bus (slave)        : codeword in, corrected data + sec/ded flags out
//   clear_i            : synchronous clear of counters and syndrome capture
//   sec_cnt_o          : saturating count of corrected beats
//   ded_cnt_o          : saturating count of uncorrectable beats
//   last_syn_o         : {overall parity, syndrome} of last erroneous beat
//   last_syn_valid_o   : last_syn_o holds a capture
// ---------------------------------------------------------------------------
module hamming_secded_dec_pipe
    import hamming_secded_pkg::*;
#(
    parameter  int DATA_WIDTH = 26,
    parameter  int CNT_WIDTH  = 16,
    localparam int N_CHECKB   = calc_checkb(DATA_WIDTH),
    localparam int CW_WIDTH   = DATA_WIDTH + N_CHECKB + 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    hamming_secded_dec_pipe_if.slave  bus,
    input  logic                      clear_i,
    output logic [CNT_WIDTH-1:0]      sec_cnt_o,
    output logic [CNT_WIDTH-1:0]      ded_cnt_o,
    output logic [N_CHECKB:0]         last_syn_o,
    output logic                      last_syn_valid_o
);

    logic [CW_WIDTH-1:0]   w_cw;
    logic [DATA_WIDTH-1:0] w_data;
    err_class_e            w_class;
    logic [N_CHECKB:0]     w_syn;
    logic                  w_isSec;
    logic                  w_isDed;
    logic                  w_ready;
    logic                  w_accept;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_sec;
    logic                  r_ded;
    logic [CNT_WIDTH-1:0]  r_secCnt;
    logic [CNT_WIDTH-1:0]  r_dedCnt;
    logic [N_CHECKB:0]     r_lastSyn;
    logic                  r_lastSynValid;

    assign w_cw = bus.hv_i;

    hamming_secded_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_cw    (w_cw),
        .o_data  (w_data),
        .o_class (w_class),
        .o_syn   (w_syn)
    );

    assign w_isSec  = (w_class == SEC);
    assign w_isDed  = (w_class == DED);

    // The single output register can take a new beat when it is empty or
    // is being emptied in this same cycle.
    assign w_ready  = ~r_valid | bus.ready_i;
    assign w_accept = bus.valid_i & w_ready;

    // Output stage: load on accept, hold while stalled, empty on pop.
    // A reset drops whatever beat is in flight.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sec   <= 1'b0;
            r_ded   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_sec   <= w_isSec;
            r_ded   <= w_isDed;
        end else if (bus.ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Error bookkeeping is updated on the accept edge. clear_i has priority,
    // so an error accepted in the clear cycle is neither counted nor captured.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear_i) begin
            r_secCnt       <= '0;
            r_dedCnt       <= '0;
            r_lastSyn      <= '0;
            r_lastSynValid <= 1'b0;
        end else if (w_accept) begin
            if (w_isSec && (r_secCnt != {CNT_WIDTH{1'b1}})) begin
                r_secCnt <= r_secCnt + 1'b1;
            end
            if (w_isDed && (r_dedCnt != {CNT_WIDTH{1'b1}})) begin
                r_dedCnt <= r_dedCnt + 1'b1;
            end
            if (w_isSec || w_isDed) begin
                r_lastSyn      <= w_syn;
                r_lastSynValid <= 1'b1;
            end
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.valid_o      = r_valid;
    assign bus.data_o       = r_data;
    assign bus.sec_o        = r_sec;
    assign bus.ded_o        = r_ded;
    assign sec_cnt_o        = r_secCnt;
    assign ded_cnt_o        = r_dedCnt;
    assign last_syn_o       = r_lastSyn;
    assign last_syn_valid_o = r_lastSynValid;

endmodule
